// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl
// Host-side echo controller for the usart block. Received bytes are taken
// through the Rx_RDY/DATA_OUT/rdy_clr handshake and buffered in a FIFO. The
// TX FSM writes them back through DATA_IN/n_WR/Tx_RDY, optionally following
// every CR (0x0D) with an inserted LF (0x0A).
//
// Handshakes:
//   RX: a byte is offered while RX_RDY=1. It is taken on the first cycle with
//       RX_RDY=1 while rx_armed is set. RDY_CLR acknowledges it one cycle
//       later for exactly one cycle, whether the byte was kept or dropped.
//       RX_RDY must fall before another byte can be taken.
//   TX: a byte is loaded only while TX_RDY=1 (the LF follow-up excepted).
//       n_WR is low for one cycle with TX_DATA stable. The transmitter is
//       then expected to drop TX_RDY and raise it again when the frame is
//       done. If TX_RDY never drops, BUSY_TIMEOUT cycles later the byte is
//       treated as sent.
//
// Ports:
//   CLK50M, RST         clock, synchronous active-high reset
//   RX_DATA, RX_RDY     received byte and its valid flag
//   RDY_CLR             one-cycle receive acknowledge
//   TX_DATA, n_WR       byte to transmit and active-low write strobe
//   TX_RDY              transmitter idle
//   ECHO_EN             allow new bytes to be popped for transmit
//   CLR_OVF             clear the sticky OVERFLOW flag
//   FIFO_LEVEL          bytes currently buffered
//   OVERFLOW            sticky: a byte was dropped on a full FIFO
//   TX_COUNT            bytes strobed to the transmitter (wraps)
//   tx_state_dbg        TX FSM state (0 idle, 1 strobe, 2 busy, 3 done)
module uart_echo_ctrl #(
  parameter int DEPTH        = 8,
  parameter bit CRLF_EN      = 1'b1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                     CLK50M,
  input  logic                     RST,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_RDY,
  output logic                     RDY_CLR,
  output logic [7:0]               TX_DATA,
  output logic                     n_WR,
  input  logic                     TX_RDY,
  input  logic                     ECHO_EN,
  input  logic                     CLR_OVF,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic                     OVERFLOW,
  output logic [15:0]              TX_COUNT,
  output logic [1:0]               tx_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_STROBE = 2'd1,
    T_BUSY   = 2'd2,
    T_DONE   = 2'd3
  } tx_state_e;

  tx_state_e         state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              lf_pend_q, lf_pend_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              rx_armed_q, rx_armed_d;
  logic              rdy_clr_q, rdy_clr_d;
  logic [7:0]        mem_q [DEPTH];

  logic              capture;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    lf_pend_d  = lf_pend_q;
    timer_d    = timer_q;
    tx_count_d = tx_count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    rx_armed_d = rx_armed_q;
    rdy_clr_d  = 1'b0;
    pop        = 1'b0;

    fifo_full  = (level_q == LW'(DEPTH));
    fifo_empty = (level_q == '0);

    // TX FSM
    case (state_q)
      T_IDLE: begin
        // A pending LF goes out ahead of the next buffered byte and does
        // not depend on ECHO_EN.
        if (lf_pend_q) begin
          tx_data_d = 8'h0A;
          lf_pend_d = 1'b0;
          state_d   = T_STROBE;
        end else if (ECHO_EN && !fifo_empty && TX_RDY) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + AW'(1);
          state_d   = T_STROBE;
        end
      end
      T_STROBE: begin
        tx_count_d = tx_count_q + 16'd1;
        if (CRLF_EN && tx_data_q == 8'h0D) lf_pend_d = 1'b1;
        timer_d = '0;
        state_d = T_BUSY;
      end
      T_BUSY: begin
        if (!TX_RDY) begin
          state_d = T_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged; give up on this byte.
          state_d = T_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      T_DONE: begin
        if (TX_RDY) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase

    // RX capture; rx_armed rearms on any cycle with RX_RDY low so that a
    // held RX_RDY yields one capture only.
    capture = RX_RDY && rx_armed_q;
    if (!RX_RDY)      rx_armed_d = 1'b1;
    else if (capture) rx_armed_d = 1'b0;
    rdy_clr_d = capture;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = capture && (!fifo_full || pop);
    drop = capture && fifo_full && !pop;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    if (drop)         ovf_d = 1'b1;
    else if (CLR_OVF) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state_q    <= T_IDLE;
      tx_data_q  <= 8'h00;
      lf_pend_q  <= 1'b0;
      timer_q    <= '0;
      tx_count_q <= 16'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rx_armed_q <= 1'b1;
      rdy_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      lf_pend_q  <= lf_pend_d;
      timer_q    <= timer_d;
      tx_count_q <= tx_count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rx_armed_q <= rx_armed_d;
      rdy_clr_q  <= rdy_clr_d;
    end
  end

  // Storage has no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge CLK50M) begin
    if (push && !RST) mem_q[wr_ptr_q] <= RX_DATA;
  end

  assign RDY_CLR      = rdy_clr_q;
  assign TX_DATA      = tx_data_q;
  assign n_WR         = (state_q != T_STROBE);
  assign FIFO_LEVEL   = level_q;
  assign OVERFLOW     = ovf_q;
  assign TX_COUNT     = tx_count_q;
  assign tx_state_dbg = state_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Testbench for uart_echo_ctrl: directed steps with a byte scoreboard and
// a simple transmitter model (TX_RDY low for 10 cycles after each strobe,
// or held high when stuck is set).
module tb_uart_echo_ctrl;

  localparam int DEPTH = 8;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rdy_clr;
  logic [7:0]  tx_data;
  logic        n_wr;
  logic        tx_rdy;
  logic        echo_en;
  logic        clr_ovf;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] tx_count;
  logic [1:0]  tx_state_dbg;

  initial forever #5 clk = ~clk;

  uart_echo_ctrl #(
    .DEPTH(DEPTH),
    .CRLF_EN(1'b1),
    .BUSY_TIMEOUT(16)
  ) dut (
    .CLK50M(clk),
    .RST(rst),
    .RX_DATA(rx_data),
    .RX_RDY(rx_rdy),
    .RDY_CLR(rdy_clr),
    .TX_DATA(tx_data),
    .n_WR(n_wr),
    .TX_RDY(tx_rdy),
    .ECHO_EN(echo_en),
    .CLR_OVF(clr_ovf),
    .FIFO_LEVEL(fifo_level),
    .OVERFLOW(overflow),
    .TX_COUNT(tx_count),
    .tx_state_dbg(tx_state_dbg)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_clr_cnt = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int last_gap = 0;
  int busy_left = 0;
  bit stuck = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Monitor + transmitter model, sampled on the falling edge.
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_clr === 1'b1) rdy_clr_cnt++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_rdy = 1'b1;
      end
      if (n_wr === 1'b0) begin
        strobe_cnt++;
        last_gap = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        check("tx_expected_byte_exists", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        if (!stuck) begin
          tx_rdy = 1'b0;
          busy_left = 10;
        end
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic send_byte(input logic [7:0] b, input int hold, input bit keep);
    rx_data = b;
    rx_rdy  = 1'b1;
    if (keep) begin
      exp_q.push_back(b);
      if (b == 8'h0D) exp_q.push_back(8'h0A);
    end
    repeat (hold) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_state_dbg == 2'd0 && fifo_level == 4'd0 && tx_rdy) begin
        done = 1'b1;
        break;
      end
    end
    check("wait_idle_in_budget", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    int rc0;
    int sc0;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_rdy = 1'b0;
    echo_en = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_rdy_clr", 32'(rdy_clr), 32'd0);
    check("rst_n_wr", 32'(n_wr), 32'd1);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single echo, RX_RDY held 3 cycles
    echo_en = 1'b1;
    rc0 = rdy_clr_cnt;
    sc0 = strobe_cnt;
    rx_data = 8'h41;
    rx_rdy = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    check("t1_level_after_capture", 32'(fifo_level), 32'd1);
    check("t1_rdy_clr_pulse", 32'(rdy_clr), 32'd1);
    @(negedge clk);
    check("t1_level_after_pop", 32'(fifo_level), 32'd0);
    check("t1_rdy_clr_one_cycle", 32'(rdy_clr), 32'd0);
    @(negedge clk);
    rx_rdy = 1'b0;
    wait_idle(200);
    check("t1_rdy_clr_count", 32'(rdy_clr_cnt - rc0), 32'd1);
    check("t1_strobe_count", 32'(strobe_cnt - sc0), 32'd1);
    check("t1_tx_count", 32'(tx_count), 32'd1);

    // 2: CR expands to CR LF
    send_byte(8'h0D, 2, 1'b1);
    repeat (2) @(negedge clk);
    send_byte(8'h42, 1, 1'b1);
    wait_idle(300);
    check("t2_tx_count", 32'(tx_count), 32'd4);

    // 3: overflow with echo disabled
    echo_en = 1'b0;
    rc0 = rdy_clr_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1, (i < DEPTH));
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_overflow_set", 32'(overflow), 32'd1);
    check("t3_rdy_clr_count", 32'(rdy_clr_cnt - rc0), 32'd10);
    check("t3_no_tx_while_disabled", 32'(tx_count), 32'd4);
    echo_en = 1'b1;
    wait_idle(600);
    check("t3_tx_count", 32'(tx_count), 32'd12);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_overflow_cleared", 32'(overflow), 32'd0);

    // 4: full FIFO, capture coincides with a pop
    echo_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1, 1'b1);
    check("t4_level_full", 32'(fifo_level), 32'd8);
    echo_en = 1'b1;
    rx_data = 8'h18;
    rx_rdy = 1'b1;
    exp_q.push_back(8'h18);
    @(negedge clk);
    check("t4_state_strobe", 32'(tx_state_dbg), 32'd1);
    check("t4_level_unchanged", 32'(fifo_level), 32'd8);
    check("t4_no_overflow", 32'(overflow), 32'd0);
    rx_rdy = 1'b0;
    wait_idle(800);
    check("t4_tx_count", 32'(tx_count), 32'd21);
    check("t4_overflow_still_clear", 32'(overflow), 32'd0);

    // 5: transmitter never drops TX_RDY -> timeout path
    stuck = 1'b1;
    echo_en = 1'b0;
    sc0 = strobe_cnt;
    send_byte(8'h55, 1, 1'b1);
    send_byte(8'h66, 1, 1'b1);
    echo_en = 1'b1;
    wait_idle(300);
    check("t5_strobe_count", 32'(strobe_cnt - sc0), 32'd2);
    check("t5_strobe_gap", 32'(last_gap), 32'd18);
    check("t5_tx_count", 32'(tx_count), 32'd23);
    stuck = 1'b0;

    // 6: reset while busy with 3 bytes buffered
    echo_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1, 1'b0);
    exp_q.push_back(8'h21);
    echo_en = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx_state_dbg == 2'd2) begin
          seen = 1'b1;
          break;
        end
      end
      check("t6_reached_busy", 32'(seen), 32'd1);
    end
    check("t6_level_before_rst", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_n_wr", 32'(n_wr), 32'd1);
    check("t6_tx_count", 32'(tx_count), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_state", 32'(tx_state_dbg), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'h00);
    sc0 = strobe_cnt;
    repeat (40) @(negedge clk);
    check("t6_no_more_strobes", 32'(strobe_cnt - sc0), 32'd0);
    check("t6_tx_count_held", 32'(tx_count), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
Host-side controller for the usart block. It consumes received bytes through the Rx_RDY/DATA_OUT/rdy_clr handshake and buffers them in a small FIFO. It then writes them back through the DATA_IN/n_WR/Tx_RDY transmit interface, optionally expanding CR to CR LF. It is used for link bring-up, loopback test and as the template for later command parsers.

Parameters:
DEPTH, 8, FIFO depth in bytes; must be a power of 2, at least 2.
CRLF_EN, 1, 1 = after transmitting 0x0D, also transmit 0x0A.
BUSY_TIMEOUT, 16, number of cycles to wait for TX_RDY to deassert after a write strobe.

Ports:
CLK50M  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
RX_DATA  in  8  received byte (from usart DATA_OUT)
RX_RDY  in  1  received byte valid (from usart Rx_RDY)
RDY_CLR  out  1  one-cycle acknowledge to receiver (to usart rdy_clr)
TX_DATA  out  8  byte to transmit (to usart DATA_IN)
n_WR  out  1  active-low one-cycle write strobe (to usart n_WR)
TX_RDY  in  1  transmitter idle and ready for a byte (from usart Tx_RDY)
ECHO_EN  in  1  1 = start transmitting buffered bytes
CLR_OVF  in  1  clears OVERFLOW
FIFO_LEVEL  out  clog2(DEPTH)+1  bytes currently buffered
OVERFLOW  out  1  sticky; set when a byte is dropped because the FIFO is full
TX_COUNT  out  16  count of bytes strobed to the transmitter, including inserted LFs; wraps at 0xFFFF

Behaviour:
- Reset values: RDY_CLR=0, n_WR=1, TX_DATA=0x00, FIFO_LEVEL=0, OVERFLOW=0, TX_COUNT=0, rx_armed=1, TX FSM=T_IDLE, LF-pending flag=0. FIFO contents are don't-care.
- RX capture:
  - Capture occurs when RX_RDY=1 and rx_armed=1.
  - The byte is pushed if not full; rx_armed clears; RDY_CLR=1 in the next cycle, for exactly one cycle.
  - rx_armed sets in any cycle in which RX_RDY=0, so a single held RX_RDY is never captured twice.
- Full FIFO:
  - A captured byte is dropped and OVERFLOW is set, but RDY_CLR is still pulsed.
  - If a pop happens in the same cycle as a push while full, the push is accepted and the level is unchanged.
- OVERFLOW clears on CLR_OVF=1. If a set and CLR_OVF occur in the same cycle, set wins.
- FIFO: circular read/write pointers with wrap at DEPTH. FIFO_LEVEL is registered and exact; simultaneous push and pop leave it unchanged.
- TX FSM:
  - T_IDLE: if LF-pending, load TX_DATA=0x0A, clear LF-pending and go to T_STROBE. Else, if ECHO_EN=1, FIFO not empty and TX_RDY=1, pop the head into TX_DATA and go to T_STROBE.
  - T_STROBE: n_WR=0 for this one cycle, with TX_DATA stable. TX_COUNT increments. If CRLF_EN=1 and TX_DATA=0x0D, set LF-pending. Go to T_BUSY and start the timeout counter.
  - T_BUSY: on TX_RDY=0, go to T_DONE. If BUSY_TIMEOUT cycles elapse with TX_RDY still 1, go to T_IDLE (no retry; the byte counts as sent).
  - T_DONE: on TX_RDY=1, go to T_IDLE.
- TX_DATA holds its value from load until the next load.
- Minimum spacing between strobes is 4 cycles plus the transmitter frame time.
- The LF is inserted before the next FIFO byte and is sent regardless of ECHO_EN.
- ECHO_EN=0 blocks only new pops from T_IDLE; a byte already in flight completes.
- RX capture and TX pop are independent and may occur in the same cycle.
- RST mid-frame: all state returns to reset values at once, and the FIFO empties. n_WR is high in the cycle after RST.

Test Plan:
- Single echo, ECHO_EN=1, transmitter model (TX_RDY low 10 cycles after strobe): RX 0x41 with RX_RDY held 3 cycles -> exactly one RDY_CLR pulse, FIFO_LEVEL 1 then 0, one n_WR low pulse with TX_DATA=0x41, TX_COUNT=1.
- CRLF with CRLF_EN=1: RX 0x0D, 0x42 -> transmitted sequence 0x0D, 0x0A, 0x42; TX_COUNT=3.
- Overflow, ECHO_EN=0, DEPTH=8: push 10 bytes 0x00..0x09 -> FIFO_LEVEL=8, OVERFLOW=1, 10 RDY_CLR pulses. Then ECHO_EN=1 -> transmits 0x00..0x07 in order. CLR_OVF -> OVERFLOW=0.
- Full with simultaneous pop: FIFO full, RX capture in the same cycle as a T_IDLE pop -> FIFO_LEVEL stays 8, new byte is sent last, OVERFLOW stays 0.
- Timeout: TX_RDY held at 1 permanently -> each strobe followed by return to T_IDLE after 16 cycles; all bytes strobed, no hang.
- Reset mid-operation: assert RST during T_BUSY with 3 bytes buffered -> next cycle FIFO_LEVEL=0, n_WR=1, TX_COUNT=0, OVERFLOW=0; no further strobes.
